// File: rtl/read_blk_sched.sv
// Per-packet read scheduler: round-robin accepts packet descriptors, walks the block chain through
// the link RAM and feeds block addresses plus the last-block marker to the SRAM read engine.
module read_blk_sched #(
    parameter int NUM_PORT   = 4,
    parameter int AWIDTH     = 14,
    parameter int BLK_AWIDTH = 10,
    parameter int BNWIDTH    = 8
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic [NUM_PORT-1:0]                        i_req_vld,
    input  logic [NUM_PORT*BLK_AWIDTH-1:0]             i_req_head,
    input  logic [NUM_PORT*BNWIDTH-1:0]                i_req_blk_num,
    input  logic [NUM_PORT*(AWIDTH-BLK_AWIDTH)-1:0]    i_req_last_n,
    output logic [NUM_PORT-1:0]                        o_req_rdy,
    output logic                                       o_lnk_rd_en,
    output logic [BLK_AWIDTH-1:0]                      o_lnk_rd_addr,
    input  logic [BLK_AWIDTH-1:0]                      i_lnk_rd_data,
    output logic [AWIDTH-1:0]                          o_blk_addr,
    output logic                                       o_blk_addr_vld,
    output logic                                       o_last_blk_vld,
    output logic [AWIDTH-BLK_AWIDTH-1:0]               o_last_blk_n,
    input  logic                                       i_read_finish,
    input  logic                                       i_read_almost_finish,
    output logic                                       o_busy,
    output logic                                       o_pkt_done,
    output logic [$clog2(NUM_PORT)-1:0]                o_pkt_port,
    output logic                                       o_err,
    output logic [1:0]                                 o_dbg_state
);

    localparam int LW = AWIDTH - BLK_AWIDTH;
    localparam int PW = $clog2(NUM_PORT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_START    = 2'd1,
        S_WAIT_AF  = 2'd2,
        S_WAIT_END = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [BLK_AWIDTH-1:0]  head_q;
    logic [BLK_AWIDTH-1:0]  nxt_q;
    logic [BNWIDTH-1:0]     blk_num_q;
    logic [BNWIDTH-1:0]     remain_q;
    logic [LW-1:0]          last_n_q;
    logic                   cap_q;
    logic                   err_pend_q;

    logic                   gnt_vld;
    logic [PW-1:0]          gnt_idx;
    logic [BLK_AWIDTH-1:0]  sel_head;
    logic [BNWIDTH-1:0]     sel_blk_num;
    logic [LW-1:0]          sel_last_n;

    assign o_dbg_state = state_q;

    // First requesting port at or after the round-robin pointer, wrapping.
    always_comb begin : rr_arb
        int p;
        p       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            p = (int'(rr_ptr_q) + i) % NUM_PORT;
            if (!gnt_vld && i_req_vld[p]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(p);
            end
        end
    end

    always_comb begin
        sel_head    = i_req_head[int'(gnt_idx)*BLK_AWIDTH +: BLK_AWIDTH];
        sel_blk_num = i_req_blk_num[int'(gnt_idx)*BNWIDTH +: BNWIDTH];
        sel_last_n  = i_req_last_n[int'(gnt_idx)*LW +: LW];
    end

    // Handshake: a requester holds i_req_vld until it sees its o_req_rdy bit for one cycle; no new
    // grant is made while that pulse is still visible, so a held valid is never accepted twice.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            head_q         <= '0;
            nxt_q          <= '0;
            blk_num_q      <= '0;
            remain_q       <= '0;
            last_n_q       <= '0;
            cap_q          <= 1'b0;
            err_pend_q     <= 1'b0;
            o_req_rdy      <= '0;
            o_lnk_rd_en    <= 1'b0;
            o_lnk_rd_addr  <= '0;
            o_blk_addr     <= '0;
            o_blk_addr_vld <= 1'b0;
            o_last_blk_vld <= 1'b0;
            o_last_blk_n   <= '0;
            o_busy         <= 1'b0;
            o_pkt_done     <= 1'b0;
            o_pkt_port     <= '0;
            o_err          <= 1'b0;
        end else begin
            o_req_rdy      <= '0;
            o_lnk_rd_en    <= 1'b0;
            o_lnk_rd_addr  <= '0;
            o_blk_addr     <= '0;
            o_blk_addr_vld <= 1'b0;
            o_last_blk_vld <= 1'b0;
            o_last_blk_n   <= '0;
            o_pkt_done     <= 1'b0;
            o_err          <= err_pend_q;
            err_pend_q     <= 1'b0;
            // Link RAM data is valid the cycle after the strobe, so capture one cycle later.
            cap_q          <= o_lnk_rd_en;
            if (cap_q) begin
                nxt_q <= i_lnk_rd_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (gnt_vld && (o_req_rdy == '0)) begin
                        o_req_rdy  <= NUM_PORT'(1) << gnt_idx;
                        rr_ptr_q   <= PW'((int'(gnt_idx) + 1) % NUM_PORT);
                        o_pkt_port <= gnt_idx;
                        head_q     <= sel_head;
                        blk_num_q  <= sel_blk_num;
                        last_n_q   <= sel_last_n;
                        if (sel_blk_num < BNWIDTH'(2)) begin
                            err_pend_q <= 1'b1;
                        end else begin
                            o_busy  <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    o_blk_addr_vld <= 1'b1;
                    o_blk_addr     <= {head_q, LW'(0)};
                    o_lnk_rd_en    <= 1'b1;
                    o_lnk_rd_addr  <= head_q;
                    remain_q       <= blk_num_q - BNWIDTH'(1);
                    state_q        <= S_WAIT_AF;
                end
                S_WAIT_AF: begin
                    if (i_read_almost_finish) begin
                        o_blk_addr_vld <= 1'b1;
                        o_blk_addr     <= {nxt_q, LW'(0)};
                        if (remain_q == BNWIDTH'(1)) begin
                            o_last_blk_vld <= 1'b1;
                            o_last_blk_n   <= last_n_q;
                            state_q        <= S_WAIT_END;
                        end else begin
                            o_lnk_rd_en   <= 1'b1;
                            o_lnk_rd_addr <= nxt_q;
                            remain_q      <= remain_q - BNWIDTH'(1);
                        end
                    end
                end
                S_WAIT_END: begin
                    // Only finish and almost-finish together mark the end of the packet.
                    if (i_read_finish && i_read_almost_finish) begin
                        o_pkt_done <= 1'b1;
                        o_busy     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_blk_sched.sv
// Bench for read_blk_sched: random descriptors, a link RAM model and a read-engine driver, with a
// monitor that checks every strobe against queues filled from a chain-walking reference model.
module tb_read_blk_sched;
  localparam int NP = 4;
  localparam int AW = 14;
  localparam int BW = 10;
  localparam int NW = 8;
  localparam int LW = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NP-1:0]     i_req_vld;
  logic [NP*BW-1:0]  i_req_head;
  logic [NP*NW-1:0]  i_req_blk_num;
  logic [NP*LW-1:0]  i_req_last_n;
  logic [NP-1:0]     o_req_rdy;
  logic              o_lnk_rd_en;
  logic [BW-1:0]     o_lnk_rd_addr;
  logic [BW-1:0]     i_lnk_rd_data = '0;
  logic [AW-1:0]     o_blk_addr;
  logic              o_blk_addr_vld;
  logic              o_last_blk_vld;
  logic [LW-1:0]     o_last_blk_n;
  logic              i_read_finish;
  logic              i_read_almost_finish;
  logic              o_busy;
  logic              o_pkt_done;
  logic [1:0]        o_pkt_port;
  logic              o_err;
  logic [1:0]        o_dbg_state;

  read_blk_sched #(.NUM_PORT(NP), .AWIDTH(AW), .BLK_AWIDTH(BW), .BNWIDTH(NW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_vld(i_req_vld), .i_req_head(i_req_head), .i_req_blk_num(i_req_blk_num),
    .i_req_last_n(i_req_last_n), .o_req_rdy(o_req_rdy),
    .o_lnk_rd_en(o_lnk_rd_en), .o_lnk_rd_addr(o_lnk_rd_addr), .i_lnk_rd_data(i_lnk_rd_data),
    .o_blk_addr(o_blk_addr), .o_blk_addr_vld(o_blk_addr_vld),
    .o_last_blk_vld(o_last_blk_vld), .o_last_blk_n(o_last_blk_n),
    .i_read_finish(i_read_finish), .i_read_almost_finish(i_read_almost_finish),
    .o_busy(o_busy), .o_pkt_done(o_pkt_done), .o_pkt_port(o_pkt_port), .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- link RAM model ----------------
  logic [BW-1:0] lnk_mem [1024];
  always @(posedge i_clk) if (o_lnk_rd_en) i_lnk_rd_data <= lnk_mem[o_lnk_rd_addr];

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int lnk_cnt = 0;
  int m_ptr   = 0;

  logic [18:0]   exp_blk_q[$];   // {last_vld, last_n, block address}
  logic [BW-1:0] exp_lnk_q[$];
  logic [1:0]    exp_gnt_q[$];
  logic [1:0]    exp_done_q[$];
  logic [1:0]    exp_err_q[$];

  logic [BW-1:0] d_head[NP];
  int            d_blk[NP];
  logic [LW-1:0] d_last[NP];
  bit            d_rnd[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin : mon
    logic [18:0] eb;
    if (i_rst_n) begin
      if (o_req_rdy != '0) begin
        chk("gnt_q_nonempty", exp_gnt_q.size() != 0, 1);
        if (exp_gnt_q.size() != 0) chk("req_rdy", o_req_rdy, 4'(1) << exp_gnt_q.pop_front());
      end
      if (o_blk_addr_vld) begin
        chk("blk_q_nonempty", exp_blk_q.size() != 0, 1);
        chk("busy_in_pkt", o_busy, 1);
        if (exp_blk_q.size() != 0) begin
          eb = exp_blk_q.pop_front();
          chk("blk_addr", {o_last_blk_vld, o_last_blk_n, o_blk_addr}, eb);
        end
      end else if (o_last_blk_vld || o_last_blk_n != '0 || o_blk_addr != '0) begin
        chk("blk_idle_zero", {o_last_blk_vld, o_last_blk_n, o_blk_addr}, 0);
      end
      if (o_lnk_rd_en) begin
        lnk_cnt++;
        chk("lnk_q_nonempty", exp_lnk_q.size() != 0, 1);
        if (exp_lnk_q.size() != 0) chk("lnk_rd_addr", o_lnk_rd_addr, exp_lnk_q.pop_front());
      end else if (o_lnk_rd_addr != '0) begin
        chk("lnk_idle_zero", o_lnk_rd_addr, 0);
      end
      if (o_pkt_done) begin
        chk("done_q_nonempty", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) chk("done_port", o_pkt_port, exp_done_q.pop_front());
      end
      if (o_err) begin
        chk("err_q_nonempty", exp_err_q.size() != 0, 1);
        chk("busy_on_err", o_busy, 0);
        if (exp_err_q.size() != 0) chk("err_port", o_pkt_port, exp_err_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic af, input logic fin);
    i_read_almost_finish = af;
    i_read_finish        = fin;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req_vld = '0;
    i_read_almost_finish = 1'b0;
    i_read_finish = 1'b0;
    #1;
    chk("rst_req_rdy", o_req_rdy, 0);
    chk("rst_lnk", {o_lnk_rd_en, o_lnk_rd_addr}, 0);
    chk("rst_blk", {o_blk_addr_vld, o_last_blk_vld, o_last_blk_n, o_blk_addr}, 0);
    chk("rst_status", {o_busy, o_pkt_done, o_pkt_port, o_err}, 0);
    exp_blk_q.delete(); exp_lnk_q.delete(); exp_gnt_q.delete();
    exp_done_q.delete(); exp_err_q.delete();
    m_ptr = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic set_req(input int p, input int head, input int blk, input int last, input bit rnd);
    d_head[p] = BW'(head);
    d_blk[p]  = blk;
    d_last[p] = LW'(last);
    d_rnd[p]  = rnd;
    i_req_head[p*BW +: BW]    = BW'(head);
    i_req_blk_num[p*NW +: NW] = NW'(blk);
    i_req_last_n[p*LW +: LW]  = LW'(last);
    i_req_vld[p] = 1'b1;
  endtask

  // Predicts the grant and the packet's responses, then plays the read engine for that packet.
  // abort_b >= 1 asserts reset after that many almost-finish pulses.
  task automatic serve_one(input int abort_b, input bit glitch, output int g);
    int cur;
    bit found;
    bit seen;
    found = 0;
    g = 0;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_ptr + i) % NP;
      if (!found && i_req_vld[p]) begin
        g = p;
        found = 1;
      end
    end
    if (!found) return;
    m_ptr = (g + 1) % NP;
    exp_gnt_q.push_back(2'(g));
    if (d_blk[g] < 2) begin
      exp_err_q.push_back(2'(g));
    end else begin
      cur = d_head[g];
      if (d_rnd[g]) begin
        for (int k = 0; k < d_blk[g] - 1; k++) begin
          int nx;
          nx = $urandom_range(0, 1023);
          lnk_mem[cur] = BW'(nx);
          cur = nx;
        end
      end
      cur = d_head[g];
      for (int k = 0; k < d_blk[g]; k++) begin
        bit last;
        last = (k == d_blk[g] - 1);
        exp_blk_q.push_back({last, last ? d_last[g] : LW'(0), BW'(cur), LW'(0)});
        if (!last) begin
          exp_lnk_q.push_back(BW'(cur));
          cur = lnk_mem[cur];
        end
      end
      exp_done_q.push_back(2'(g));
    end

    seen = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge i_clk);
      seen = o_req_rdy[g];
    end
    chk("rdy_seen", seen, 1);
    if (!seen) return;
    i_req_vld[g] = 1'b0;
    lnk_cnt = 0;

    if (d_blk[g] < 2) begin
      seen = 0;
      for (int t = 0; t < 5 && !seen; t++) begin
        @(negedge i_clk);
        seen = o_err;
      end
      chk("err_seen", seen, 1);
      chk("busy_after_err", o_busy, 0);
      return;
    end

    drive_cycle(glitch, 1'b0);
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
    for (int b = 1; b < d_blk[g]; b++) begin
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b0, glitch && ($urandom_range(0, 1) == 1));
      drive_cycle(1'b0, 1'b0);
      if (b == abort_b) begin
        do_reset();
        return;
      end
      repeat ($urandom_range(0, 3)) drive_cycle(1'b0, 1'b0);
    end
    if (glitch) begin
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b0, 1'b1);
    end
    drive_cycle(1'b1, 1'b1);
    i_read_almost_finish = 1'b0;
    i_read_finish = 1'b0;
    seen = 0;
    for (int t = 0; t < 5 && !seen; t++) begin
      seen = o_pkt_done;
      if (!seen) @(negedge i_clk);
    end
    chk("done_seen", seen, 1);
    chk("lnk_cnt", lnk_cnt, d_blk[g] - 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int mask;
    i_rst_n = 1'b1;
    i_req_vld = '0;
    i_req_head = '0;
    i_req_blk_num = '0;
    i_req_last_n = '0;
    i_read_finish = 1'b0;
    i_read_almost_finish = 1'b0;
    for (int i = 0; i < 1024; i++) lnk_mem[i] = BW'($urandom_range(0, 1023));
    @(negedge i_clk);
    do_reset();

    // All ports requesting continuously from reset, then only ports 0 and 3.
    for (int p = 0; p < NP; p++)
      set_req(p, $urandom_range(0, 1023), $urandom_range(2, 4), $urandom_range(0, 15), 1);
    repeat (5) begin
      serve_one(-1, 0, g);
      set_req(g, $urandom_range(0, 1023), $urandom_range(2, 4), $urandom_range(0, 15), 1);
    end
    serve_one(-1, 0, g);
    i_req_vld[2] = 1'b0;
    serve_one(-1, 1, g);
    serve_one(-1, 0, g);

    // Three-block packet on port 2 with chain 5->9->12.
    lnk_mem[5] = 10'd9;
    lnk_mem[9] = 10'd12;
    set_req(2, 5, 3, 7, 0);
    serve_one(-1, 0, g);

    // Rejected descriptors.
    set_req(1, 100, 1, 3, 1);
    serve_one(-1, 0, g);
    set_req(1, 200, 0, 3, 1);
    serve_one(-1, 0, g);

    // Two-block packet, with stray finish/almost-finish pulses.
    lnk_mem[3] = 10'd4;
    set_req(3, 3, 2, 9, 0);
    serve_one(-1, 1, g);

    // Reset in the middle of a packet, then a fresh packet on port 0.
    set_req(0, $urandom_range(0, 1023), 5, 2, 1);
    serve_one(1, 0, g);
    set_req(0, $urandom_range(0, 1023), 3, 11, 1);
    serve_one(-1, 0, g);

    // Random mix of ports, lengths and engine glitches.
    for (int n = 0; n < 30; n++) begin
      mask = $urandom_range(1, 15);
      for (int p = 0; p < NP; p++)
        if (mask[p] && !i_req_vld[p])
          set_req(p, $urandom_range(0, 1023), $urandom_range(0, 6), $urandom_range(0, 15), 1);
      serve_one(-1, $urandom_range(0, 1), g);
    end
    for (int n = 0; n < NP && i_req_vld != '0; n++) serve_one(-1, 1, g);

    repeat (5) @(negedge i_clk);
    chk("end_blk_q", exp_blk_q.size(), 0);
    chk("end_lnk_q", exp_lnk_q.size(), 0);
    chk("end_gnt_q", exp_gnt_q.size(), 0);
    chk("end_done_q", exp_done_q.size(), 0);
    chk("end_err_q", exp_err_q.size(), 0);
    chk("end_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
